// File: rtl/uart_tx_arbiter_if.sv
// Requester byte-stream and uart_tx handshake bundle for uart_tx_arbiter.
// slave = arbiter side, master = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]            in_last;
    logic [NUM_REQ-1:0]            in_ready;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          data_ack;
    logic                          tx_busy;

    modport slave (
        input  in_valid, in_data, in_last, data_ack, tx_busy,
        output in_ready, tx_start, tx_data
    );

    modport master (
        output in_valid, in_data, in_last, data_ack, tx_busy,
        input  in_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock that feeds one uart_tx from NUM_REQ
// byte-stream requesters through a single-entry holding register.
module uart_tx_arbiter #(
    parameter  int NUM_REQ    = 3,
    parameter  int DATA_WIDTH = 8,
    localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    uart_tx_arbiter_if.slave     bus,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 locked,
    output logic                 idle
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state;
    logic [IDX_WIDTH-1:0]  rr_ptr;
    logic                  tx_start_q;
    logic [DATA_WIDTH-1:0] tx_data_q;

    logic                  win_found;
    logic [IDX_WIDTH-1:0]  win_idx;
    logic [IDX_WIDTH-1:0]  cand;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  win_last;
    logic                  capture;
    logic [NUM_REQ-1:0]    ready;

    // A locked packet restricts the candidate set to its owner; otherwise
    // the first valid requester at or after rr_ptr (wrapping) wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (locked) begin
            win_found = bus.in_valid[grant_idx];
            win_idx   = grant_idx;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
                if (!win_found && bus.in_valid[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_WIDTH'(i)) begin
                win_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_last = bus.in_last[i];
            end
        end
    end

    assign capture = (state == EMPTY) && enable && win_found;

    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready[i] = capture && (win_idx == IDX_WIDTH'(i));
        end
    end

    assign bus.in_ready = ready;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign idle         = (state == EMPTY) && !locked && !bus.tx_busy;

    // The capture in EMPTY and the release on data_ack never overlap, so one
    // state bit fully describes the holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            tx_start_q <= 1'b0;
            // NOTE: the holding register is reset too, so a byte caught mid-packet is discarded, not replayed.
            tx_data_q  <= '0;
            grant_idx  <= '0;
            rr_ptr     <= '0;
            locked     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                EMPTY: begin
                    if (capture) begin
                        state      <= FULL;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= win_data;
                        grant_idx  <= win_idx;
                        rr_ptr     <= (win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                        locked     <= !win_last;
                    end
                end
                FULL: begin
                    if (bus.data_ack) begin
                        state      <= EMPTY;
                        tx_start_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    tx_start_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
